// File: rtl/scan_index_gen_pkg.sv
// Shared definitions for the scan index generator: state encoding and index width.
package scan_index_gen_pkg;

  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DWELL = 2'd2
  } scan_state_t;

endpackage

// File: rtl/dwell_timer.sv
// Down-counter shared by the BLANK and DWELL intervals; expires when the count reaches zero.
module dwell_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/scan_index_gen.sv
// Scan index sequencer for a 4-to-16 decoder: blank gap, then a dwell per index,
// in free-run or single-sweep mode, with hold and abort.
module scan_index_gen
  import scan_index_gen_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DWELL = 50000,
  parameter int BLANK = 4,
  parameter int LAST  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             hold,
  input  logic             stop,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             busy,
  output logic             sweep_done
);

  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);

  // Entering a new index goes through BLANK unless blanking is disabled,
  // in which case idx and idx_valid move together straight into DWELL.
  localparam scan_state_t      ENTRY_STATE = (BLANK > 0) ? S_BLANK : S_DWELL;
  localparam logic             ENTRY_VALID = (BLANK > 0) ? 1'b0 : 1'b1;
  localparam logic [CNT_W-1:0] ENTRY_LD    = (BLANK > 0) ? BLANK_LD : DWELL_LD;

  scan_state_t      state, state_n;
  logic [IDX_W-1:0] idx_n;
  logic             valid_n, busy_n, done_n;
  logic             mode_q, mode_n;
  logic             t_load, t_en, t_expired;
  logic [CNT_W-1:0] t_val;

  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .expired  (t_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      idx_valid  <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      idx_valid  <= valid_n;
      busy       <= busy_n;
      sweep_done <= done_n;
      mode_q     <= mode_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    valid_n = idx_valid;
    busy_n  = busy;
    done_n  = 1'b0;
    mode_n  = mode_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_en    = 1'b0;

    if (stop) begin
      state_n = S_IDLE;
      idx_n   = '0;
      valid_n = 1'b0;
      busy_n  = 1'b0;
      t_load  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_n  = mode;
            idx_n   = '0;
            busy_n  = 1'b1;
            state_n = ENTRY_STATE;
            valid_n = ENTRY_VALID;
            t_load  = 1'b1;
            t_val   = ENTRY_LD;
          end
        end
        S_BLANK: begin
          if (!hold) begin
            if (t_expired) begin
              state_n = S_DWELL;
              valid_n = 1'b1;
              t_load  = 1'b1;
              t_val   = DWELL_LD;
            end else begin
              t_en = 1'b1;
            end
          end
        end
        S_DWELL: begin
          if (!hold) begin
            if (!t_expired) begin
              t_en = 1'b1;
            end else if ((idx != LAST_IDX) || !mode_q) begin
              idx_n   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
              state_n = ENTRY_STATE;
              valid_n = ENTRY_VALID;
              t_load  = 1'b1;
              t_val   = ENTRY_LD;
            end else begin
              state_n = S_IDLE;
              idx_n   = '0;
              valid_n = 1'b0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end
          end
        end
        default: begin
          state_n = S_IDLE;
          idx_n   = '0;
          valid_n = 1'b0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_index_gen.sv
// Scoreboard bench: stimulus queues expected dwell segments {idx, length}; a negedge monitor
// reconstructs segments from idx/idx_valid and checks them, plus blank-gap lengths.
module tb_scan_index_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_a = 1'b0, mode_a = 1'b0, hold_a = 1'b0, stop_a = 1'b0;
  logic       start_b = 1'b0, mode_b = 1'b0, hold_b = 1'b0, stop_b = 1'b0;
  logic [3:0] idx_a, idx_b;
  logic       valid_a, busy_a, done_a;
  logic       valid_b, busy_b, done_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  int q0[$];
  int q1[$];
  int seg_open[2];
  int seg_idx[2];
  int seg_len[2];
  int gap[2];

  scan_index_gen #(.CNT_W(16), .DWELL(3), .BLANK(2), .LAST(15)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode_a), .hold(hold_a), .stop(stop_a),
    .idx(idx_a), .idx_valid(valid_a), .busy(busy_a), .sweep_done(done_a)
  );

  scan_index_gen #(.CNT_W(16), .DWELL(3), .BLANK(0), .LAST(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode_b), .hold(hold_b), .stop(stop_b),
    .idx(idx_b), .idx_valid(valid_b), .busy(busy_b), .sweep_done(done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_seg(input int k, input int ix, input int len);
    if (k == 0) q0.push_back(ix * 100 + len);
    else        q1.push_back(ix * 100 + len);
  endtask

  task automatic mon_step(input int k, input logic v, input logic b, input logic [3:0] ix,
                          input int exp_gap);
    int e;
    if (seg_open[k] != 0 && (!v || int'(ix) != seg_idx[k])) begin
      if ((k == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        chk($sformatf("seg_unexpected_%0d", k), seg_idx[k], -1);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("seg_idx_%0d", k), seg_idx[k], e / 100);
        chk($sformatf("seg_len_%0d_idx%0d", k, seg_idx[k]), seg_len[k], e % 100);
      end
      seg_open[k] = 0;
    end
    if (v && seg_open[k] == 0) begin
      chk($sformatf("gap_%0d_idx%0d", k, ix), gap[k], exp_gap);
      seg_open[k] = 1;
      seg_idx[k]  = int'(ix);
      seg_len[k]  = 1;
      gap[k]      = 0;
    end else if (v) begin
      seg_len[k]++;
    end else if (b) begin
      gap[k]++;
    end else begin
      gap[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, valid_a, busy_a, idx_a, 2);
    mon_step(1, valid_b, busy_b, idx_b, 0);
    if (busy_b) chk("b_valid_const", int'(valid_b), 1);
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  task automatic start_pulse_a(input logic m);
    @(negedge clk);
    start_a = 1'b1;
    mode_a  = m;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start_a = 1'b0;
    chk("a_busy_after_start", int'(busy_a), 1);
  endtask

  task automatic wait_idx_a(input logic [3:0] want);
    bit found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (valid_a && idx_a == want) found = 1;
    end
    if (!found) chk("timeout_wait_idx", -1, int'(want));
  endtask

  task automatic wait_done_a(input int exp_cycles);
    bit found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (done_a) found = 1;
    end
    if (!found) begin
      chk("timeout_sweep_done", -1, exp_cycles);
    end else begin
      chk("sweep_done_latency", cyc - start_cyc, exp_cycles);
      chk("busy_at_done", int'(busy_a), 0);
      chk("idx_at_done", int'(idx_a), 0);
      chk("valid_at_done", int'(valid_a), 0);
      @(negedge clk);
      chk("done_one_cycle", int'(done_a), 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      seg_open[k] = 0; seg_idx[k] = 0; seg_len[k] = 0; gap[k] = 0;
    end
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idx", int'(idx_a), 0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_b_busy", int'(busy_b), 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: single sweep; mode flipped while busy must be ignored
    for (int i = 0; i < 16; i++) push_seg(0, i, 3);
    start_pulse_a(1'b1);
    mode_a = 1'b0;
    wait_done_a(80);

    // 2 + 4: free-run wraps 15 -> 0, then stop together with hold at idx 9 of lap two
    for (int i = 0; i < 16; i++) push_seg(0, i, 3);
    for (int i = 0; i < 9; i++) push_seg(0, i, 3);
    push_seg(0, 9, 1);
    start_pulse_a(1'b0);
    wait_idx_a(4'd15);
    wait_idx_a(4'd0);
    chk("freerun_busy_wrap", int'(busy_a), 1);
    chk("freerun_no_done", done_cnt_a, 1);
    wait_idx_a(4'd9);
    stop_a = 1'b1;
    hold_a = 1'b1;
    @(posedge clk);
    #1;
    stop_a = 1'b0;
    hold_a = 1'b0;
    chk("stop_idx", int'(idx_a), 0);
    chk("stop_valid", int'(valid_a), 0);
    chk("stop_busy", int'(busy_a), 0);
    chk("stop_done", int'(done_a), 0);

    // 3: hold for 10 cycles in dwell cycle 2 of idx 5
    for (int i = 0; i < 5; i++) push_seg(0, i, 3);
    push_seg(0, 5, 13);
    for (int i = 6; i < 16; i++) push_seg(0, i, 3);
    start_pulse_a(1'b1);
    wait_idx_a(4'd5);
    @(negedge clk);
    hold_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) begin
        chk("hold_idx", int'(idx_a), 5);
        chk("hold_valid", int'(valid_a), 1);
      end
    end
    hold_a = 1'b0;
    wait_done_a(90);

    // 5: asynchronous reset mid-dwell at idx 7; start during reset ignored
    for (int i = 0; i < 7; i++) push_seg(0, i, 3);
    push_seg(0, 7, 2);
    start_pulse_a(1'b1);
    wait_idx_a(4'd7);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_idx", int'(idx_a), 0);
    chk("async_rst_valid", int'(valid_a), 0);
    chk("async_rst_busy", int'(busy_a), 0);
    @(negedge clk);
    start_a = 1'b1;
    repeat (2) @(negedge clk);
    start_a = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", int'(busy_a), 0);
    chk("post_rst_valid", int'(valid_a), 0);

    // 6: no blanking, LAST=3, free-run; start while busy ignored
    push_seg(1, 0, 3); push_seg(1, 1, 3); push_seg(1, 2, 3);
    push_seg(1, 3, 3); push_seg(1, 0, 3); push_seg(1, 1, 1);
    @(negedge clk);
    start_b = 1'b1;
    mode_b  = 1'b0;
    @(posedge clk);
    #1 start_b = 1'b0;
    chk("b_valid_at_start", int'(valid_b), 1);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 7) start_b = 1'b1;
      if (n == 8) start_b = 1'b0;
    end
    stop_b = 1'b1;
    @(posedge clk);
    #1 stop_b = 1'b0;
    chk("b_stop_busy", int'(busy_b), 0);
    chk("b_stop_idx", int'(idx_b), 0);
    repeat (3) @(negedge clk);

    chk("a_queue_empty", q0.size(), 0);
    chk("b_queue_empty", q1.size(), 0);
    chk("a_done_count", done_cnt_a, 2);
    chk("b_done_count", done_cnt_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", cyc);
    $fatal(1, "timeout");
  end

endmodule
